mc_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS32 datapath. It sequences the program counter, instruction register, unified memory port, ALU and register file across FETCH/DECODE/EXEC/MEM/WB states. It sits beside the PC register (reset vector 0x0000_3000) and drives that register's write-enable and next-PC source select. It supports addu, subu, ori, lui, lw, sw, beq, j, jal, jr and nop, and holds a sticky illegal-instruction trap.

---
 rtl/mc_pkg.sv | 79 +++++++
 rtl/mc_decode.sv | 43 ++++
 rtl/mc_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle MIPS32 control slice.
// Holds the opcode/funct encodings, the FSM state encoding, the decoded
// instruction classes, and the encodings of every datapath select field
// (pc_sel, wd_sel, reg_dst, alu_op, ext_op, mem_addr_sel).
package mc_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_NOP  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB,
    ST_BRANCH,
    ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_ADDU,
    CLS_SUBU,
    CLS_ORI,
    CLS_LUI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_JAL,
    CLS_JR,
    CLS_NOP,
    CLS_ILLEGAL
  } instr_cls_e;

  // Next-PC source
  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
  localparam logic [1:0] PC_SEL_RS     = 2'd3;

  // Register-file write data source
  localparam logic [1:0] WD_SEL_ALU = 2'd0;
  localparam logic [1:0] WD_SEL_MEM = 2'd1;
  localparam logic [1:0] WD_SEL_PC  = 2'd2;

  // Register-file destination
  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  // ALU operation
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;

  // Immediate extension
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  // Memory address source
  localparam logic MEM_ADDR_PC  = 1'b0;
  localparam logic MEM_ADDR_ALU = 1'b1;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: purely combinational classifier of the instruction register.
// Ports:
//   ir_op, ir_funct : opcode and funct fields of the held instruction
//   cls             : decoded instruction class (instr_cls_e encoding)
//   is_illegal      : encoding is not one of the supported instructions
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] ir_op,
  input  logic [5:0] ir_funct,
  output logic [3:0] cls,
  output logic       is_illegal
);

  instr_cls_e cls_e;

  always_comb begin
    cls_e = CLS_ILLEGAL;
    case (ir_op)
      OP_RTYPE: begin
        case (ir_funct)
          FN_ADDU: cls_e = CLS_ADDU;
          FN_SUBU: cls_e = CLS_SUBU;
          FN_JR:   cls_e = CLS_JR;
          FN_NOP:  cls_e = CLS_NOP;
          default: cls_e = CLS_ILLEGAL;
        endcase
      end
      OP_ORI:  cls_e = CLS_ORI;
      OP_LUI:  cls_e = CLS_LUI;
      OP_LW:   cls_e = CLS_LW;
      OP_SW:   cls_e = CLS_SW;
      OP_BEQ:  cls_e = CLS_BEQ;
      OP_J:    cls_e = CLS_J;
      OP_JAL:  cls_e = CLS_JAL;
      default: cls_e = CLS_ILLEGAL;
    endcase
  end

  assign cls        = cls_e;
  assign is_illegal = (cls_e == CLS_ILLEGAL);

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS32 datapath.
// Sequences FETCH/DECODE/EXEC/MEM_RD/MEM_WR/WB/BRANCH and a sticky TRAP.
// Ports:
//   clk, reset         : clock and synchronous active-high reset
//   ir_op, ir_funct    : held instruction register fields
//   alu_zero           : ALU result is zero (beq compare)
//   mem_ready          : memory completes the current request this cycle
//   pc_we, pc_sel      : PC load strobe and next-PC source
//   ir_we              : instruction register load
//   mem_req, mem_we    : memory request / write qualifier
//   mem_addr_sel       : memory address source (PC or ALU)
//   reg_we, reg_dst    : register write strobe and destination
//   wd_sel             : register write data source
//   alu_op, alu_src_imm, ext_op : ALU control
//   illegal            : sticky illegal-instruction flag
//   retired            : count of completed instructions (wraps)
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       ir_op,
  input  logic [5:0]       ir_funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             ir_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic [1:0]       alu_op,
  output logic             alu_src_imm,
  output logic [1:0]       ext_op,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  logic [3:0]  cls_bits;
  logic        is_illegal;
  instr_cls_e  cls;

  // ALU setup implied by the held instruction; applied from EXEC onward
  logic [1:0]  cls_alu_op;
  logic        cls_alu_imm;
  logic [1:0]  cls_ext_op;

  mc_decode u_decode (
    .ir_op      (ir_op),
    .ir_funct   (ir_funct),
    .cls        (cls_bits),
    .is_illegal (is_illegal)
  );

  assign cls = instr_cls_e'(cls_bits);

  always_comb begin
    cls_alu_op  = ALU_ADD;
    cls_alu_imm = 1'b0;
    cls_ext_op  = EXT_ZERO;
    case (cls)
      CLS_SUBU: cls_alu_op = ALU_SUB;
      CLS_ORI: begin
        cls_alu_op  = ALU_OR;
        cls_alu_imm = 1'b1;
        cls_ext_op  = EXT_ZERO;
      end
      CLS_LUI: begin
        cls_alu_op  = ALU_OR;
        cls_alu_imm = 1'b1;
        cls_ext_op  = EXT_LUI;
      end
      CLS_LW, CLS_SW: begin
        cls_alu_op  = ALU_ADD;
        cls_alu_imm = 1'b1;
        cls_ext_op  = EXT_SIGN;
      end
      default: ;
    endcase
  end

  // Moore outputs and next state. Reset is folded in last so that it
  // silences every output and forces the next-state values.
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    retire       = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_PLUS4;
    ir_we        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = MEM_ADDR_PC;
    reg_we       = 1'b0;
    reg_dst      = REG_DST_RT;
    wd_sel       = WD_SEL_ALU;
    alu_op       = ALU_ADD;
    alu_src_imm  = 1'b0;
    ext_op       = EXT_ZERO;

    case (state_q)
      ST_FETCH: begin
        mem_req      = 1'b1;
        mem_addr_sel = MEM_ADDR_PC;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          pc_sel  = PC_SEL_PLUS4;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          case (cls)
            CLS_BEQ: state_d = ST_BRANCH;
            CLS_J: begin
              pc_we   = 1'b1;
              pc_sel  = PC_SEL_JUMP;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
            CLS_JAL: begin
              pc_we   = 1'b1;
              pc_sel  = PC_SEL_JUMP;
              reg_we  = 1'b1;
              reg_dst = REG_DST_RA;
              wd_sel  = WD_SEL_PC;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
            CLS_JR: begin
              pc_we   = 1'b1;
              pc_sel  = PC_SEL_RS;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
            CLS_NOP: begin
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
            default: state_d = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: begin
        alu_op      = cls_alu_op;
        alu_src_imm = cls_alu_imm;
        ext_op      = cls_ext_op;
        if (cls == CLS_LW)      state_d = ST_MEM_RD;
        else if (cls == CLS_SW) state_d = ST_MEM_WR;
        else                    state_d = ST_WB;
      end
      ST_MEM_RD: begin
        alu_op       = cls_alu_op;
        alu_src_imm  = cls_alu_imm;
        ext_op       = cls_ext_op;
        mem_req      = 1'b1;
        mem_addr_sel = MEM_ADDR_ALU;
        if (mem_ready) state_d = ST_WB;
      end
      ST_MEM_WR: begin
        alu_op       = cls_alu_op;
        alu_src_imm  = cls_alu_imm;
        ext_op       = cls_ext_op;
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr_sel = MEM_ADDR_ALU;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        alu_op      = cls_alu_op;
        alu_src_imm = cls_alu_imm;
        ext_op      = cls_ext_op;
        reg_we      = 1'b1;
        if (cls == CLS_ADDU || cls == CLS_SUBU) begin
          reg_dst = REG_DST_RD;
          wd_sel  = WD_SEL_ALU;
        end else if (cls == CLS_LW) begin
          reg_dst = REG_DST_RT;
          wd_sel  = WD_SEL_MEM;
        end else begin
          reg_dst = REG_DST_RT;
          wd_sel  = WD_SEL_ALU;
        end
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_op = ALU_SUB;
        ext_op = EXT_SIGN;
        if (alu_zero) begin
          pc_we  = 1'b1;
          pc_sel = PC_SEL_BRANCH;
        end
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};

    if (reset) begin
      pc_we        = 1'b0;
      pc_sel       = PC_SEL_PLUS4;
      ir_we        = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = MEM_ADDR_PC;
      reg_we       = 1'b0;
      reg_dst      = REG_DST_RT;
      wd_sel       = WD_SEL_ALU;
      alu_op       = ALU_ADD;
      alu_src_imm  = 1'b0;
      ext_op       = EXT_ZERO;
      state_d      = ST_FETCH;
      illegal_d    = 1'b0;
      retired_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    illegal_q <= illegal_d;
    retired_q <= retired_d;
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed, self-checking bench for mc_ctrl. Each cycle the
// stimulus and the expected control word are pushed to a scoreboard and
// compared against the DUT outputs mid-cycle.
module tb_mc_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  ir_op;
  logic [5:0]  ir_funct;
  logic        alu_zero;
  logic        mem_ready;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        ir_we;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic [1:0]  alu_op;
  logic        alu_src_imm;
  logic [1:0]  ext_op;
  logic        illegal;
  logic [31:0] retired;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .ir_op        (ir_op),
    .ir_funct     (ir_funct),
    .alu_zero     (alu_zero),
    .mem_ready    (mem_ready),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .ir_we        (ir_we),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .reg_we       (reg_we),
    .reg_dst      (reg_dst),
    .wd_sel       (wd_sel),
    .alu_op       (alu_op),
    .alu_src_imm  (alu_src_imm),
    .ext_op       (ext_op),
    .illegal      (illegal),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [16:0] ctrl;
    logic        ill;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic        ill_exp;
  logic [31:0] ret_exp;

  function automatic logic [16:0] pk(
    input logic pwe, input logic [1:0] psel, input logic irw,
    input logic mrq, input logic mwe, input logic mas, input logic rwe,
    input logic [1:0] rdst, input logic [1:0] wds, input logic [1:0] aop,
    input logic aimm, input logic [1:0] ext);
    return {pwe, psel, irw, mrq, mwe, mas, rwe, rdst, wds, aop, aimm, ext};
  endfunction

  // One cycle: drive inputs after the falling edge, queue the expectation,
  // then compare while the outputs are stable ahead of the rising edge.
  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic [5:0] fn, input logic zero, input logic rdy,
                      input logic [16:0] exp_ctrl);
    exp_t e;
    exp_t got;
    logic [16:0] obs;
    @(negedge clk);
    reset     = rst;
    ir_op     = op;
    ir_funct  = fn;
    alu_zero  = zero;
    mem_ready = rdy;
    e.tag  = tag;
    e.ctrl = exp_ctrl;
    e.ill  = ill_exp;
    e.ret  = ret_exp;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    obs = {pc_we, pc_sel, ir_we, mem_req, mem_we, mem_addr_sel, reg_we,
           reg_dst, wd_sel, alu_op, alu_src_imm, ext_op};
    checks++;
    assert ({obs, illegal, retired} === {got.ctrl, got.ill, got.ret})
      else begin
        errors++;
        $error("[TB] FAIL %s: observed ctrl=%h illegal=%b retired=%0d, expected ctrl=%h illegal=%b retired=%0d",
               got.tag, obs, illegal, retired, got.ctrl, got.ill, got.ret);
      end
  endtask

  localparam logic [5:0] R = 6'b000000;

  initial begin
    logic [16:0] z, fw, fd, ex_add, wb_add, ex_sub, wb_sub, ex_ori, wb_ori;
    logic [16:0] ex_lui, wb_lui, ex_mem, mrd, wb_lw, mwr, br_t, br_n;
    logic [16:0] d_jal, d_j, d_jr;

    z      = '0;
    fw     = pk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
    fd     = pk(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
    ex_add = '0;
    wb_add = pk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0);
    ex_sub = pk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, 2'd0);
    wb_sub = pk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd1, 1'b0, 2'd0);
    ex_ori = pk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 2'd0);
    wb_ori = pk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd2, 1'b1, 2'd0);
    ex_lui = pk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 2'd2);
    wb_lui = pk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd2, 1'b1, 2'd2);
    ex_mem = pk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd1);
    mrd    = pk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd1);
    wb_lw  = pk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd0, 1'b1, 2'd1);
    mwr    = pk(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd1);
    br_t   = pk(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, 2'd1);
    br_n   = pk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, 2'd1);
    d_jal  = pk(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd0, 1'b0, 2'd0);
    d_j    = pk(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
    d_jr   = pk(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);

    reset = 1'b1; ir_op = '0; ir_funct = '0; alu_zero = 1'b0; mem_ready = 1'b1;
    ill_exp = 1'b0;
    ret_exp = 32'd0;

    step("reset", 1'b1, R, 6'b000000, 1'b0, 1'b1, z);

    // addu: 4 cycles, reg_we only in WB
    step("addu_fetch",  1'b0, R, 6'b100001, 1'b0, 1'b1, fd);
    step("addu_decode", 1'b0, R, 6'b100001, 1'b0, 1'b1, z);
    step("addu_exec",   1'b0, R, 6'b100001, 1'b0, 1'b1, ex_add);
    step("addu_wb",     1'b0, R, 6'b100001, 1'b0, 1'b1, wb_add);
    ret_exp++;

    // lw with two memory wait cycles
    step("lw_fetch",  1'b0, 6'b100011, 6'd0, 1'b0, 1'b1, fd);
    step("lw_decode", 1'b0, 6'b100011, 6'd0, 1'b0, 1'b1, z);
    step("lw_exec",   1'b0, 6'b100011, 6'd0, 1'b0, 1'b1, ex_mem);
    step("lw_mrd_w1", 1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, mrd);
    step("lw_mrd_w2", 1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, mrd);
    step("lw_mrd_rdy",1'b0, 6'b100011, 6'd0, 1'b0, 1'b1, mrd);
    step("lw_wb",     1'b0, 6'b100011, 6'd0, 1'b0, 1'b1, wb_lw);
    ret_exp++;

    // sw with one fetch wait cycle
    step("sw_fetch_w", 1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, fw);
    step("sw_fetch",   1'b0, 6'b101011, 6'd0, 1'b0, 1'b1, fd);
    step("sw_decode",  1'b0, 6'b101011, 6'd0, 1'b0, 1'b1, z);
    step("sw_exec",    1'b0, 6'b101011, 6'd0, 1'b0, 1'b1, ex_mem);
    step("sw_mwr",     1'b0, 6'b101011, 6'd0, 1'b0, 1'b1, mwr);
    ret_exp++;

    // beq taken, then not taken
    step("beqt_fetch",  1'b0, 6'b000100, 6'd0, 1'b1, 1'b1, fd);
    step("beqt_decode", 1'b0, 6'b000100, 6'd0, 1'b1, 1'b1, z);
    step("beqt_branch", 1'b0, 6'b000100, 6'd0, 1'b1, 1'b1, br_t);
    ret_exp++;
    step("beqn_fetch",  1'b0, 6'b000100, 6'd0, 1'b0, 1'b1, fd);
    step("beqn_decode", 1'b0, 6'b000100, 6'd0, 1'b0, 1'b1, z);
    step("beqn_branch", 1'b0, 6'b000100, 6'd0, 1'b0, 1'b1, br_n);
    ret_exp++;

    // ori, lui, subu
    step("ori_fetch",  1'b0, 6'b001101, 6'd0, 1'b0, 1'b1, fd);
    step("ori_decode", 1'b0, 6'b001101, 6'd0, 1'b0, 1'b1, z);
    step("ori_exec",   1'b0, 6'b001101, 6'd0, 1'b0, 1'b1, ex_ori);
    step("ori_wb",     1'b0, 6'b001101, 6'd0, 1'b0, 1'b1, wb_ori);
    ret_exp++;
    step("lui_fetch",  1'b0, 6'b001111, 6'd0, 1'b0, 1'b1, fd);
    step("lui_decode", 1'b0, 6'b001111, 6'd0, 1'b0, 1'b1, z);
    step("lui_exec",   1'b0, 6'b001111, 6'd0, 1'b0, 1'b1, ex_lui);
    step("lui_wb",     1'b0, 6'b001111, 6'd0, 1'b0, 1'b1, wb_lui);
    ret_exp++;
    step("subu_fetch",  1'b0, R, 6'b100011, 1'b0, 1'b1, fd);
    step("subu_decode", 1'b0, R, 6'b100011, 1'b0, 1'b1, z);
    step("subu_exec",   1'b0, R, 6'b100011, 1'b0, 1'b1, ex_sub);
    step("subu_wb",     1'b0, R, 6'b100011, 1'b0, 1'b1, wb_sub);
    ret_exp++;

    // jumps and nop: two cycles each
    step("jal_fetch",  1'b0, 6'b000011, 6'd0, 1'b0, 1'b1, fd);
    step("jal_decode", 1'b0, 6'b000011, 6'd0, 1'b0, 1'b1, d_jal);
    ret_exp++;
    step("j_fetch",    1'b0, 6'b000010, 6'd0, 1'b0, 1'b1, fd);
    step("j_decode",   1'b0, 6'b000010, 6'd0, 1'b0, 1'b1, d_j);
    ret_exp++;
    step("jr_fetch",   1'b0, R, 6'b001000, 1'b0, 1'b1, fd);
    step("jr_decode",  1'b0, R, 6'b001000, 1'b0, 1'b1, d_jr);
    ret_exp++;
    step("nop_fetch",  1'b0, R, 6'b000000, 1'b0, 1'b1, fd);
    step("nop_decode", 1'b0, R, 6'b000000, 1'b0, 1'b1, z);
    ret_exp++;

    // illegal opcode: trap absorbs, no strobes, not retired
    step("ill_fetch",  1'b0, 6'b111111, 6'd0, 1'b0, 1'b1, fd);
    step("ill_decode", 1'b0, 6'b111111, 6'd0, 1'b0, 1'b1, z);
    ill_exp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step("ill_trap", 1'b0, 6'b111111, 6'd0, 1'b1, 1'b1, z);
    end
    step("ill_reset", 1'b1, 6'b111111, 6'd0, 1'b0, 1'b1, z);
    ill_exp = 1'b0;
    ret_exp = 32'd0;
    step("post_reset_fetch", 1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, fw);

    // reset in the middle of a waiting store
    step("sw2_fetch",  1'b0, 6'b101011, 6'd0, 1'b0, 1'b1, fd);
    step("sw2_decode", 1'b0, 6'b101011, 6'd0, 1'b0, 1'b1, z);
    step("sw2_exec",   1'b0, 6'b101011, 6'd0, 1'b0, 1'b1, ex_mem);
    step("sw2_mwr_w",  1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, mwr);
    step("sw2_reset",  1'b1, 6'b101011, 6'd0, 1'b0, 1'b0, z);
    step("sw2_after",  1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, fw);
    step("sw2_after2", 1'b0, 6'b101011, 6'd0, 1'b0, 1'b1, fd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
